// File: rtl/uart_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_lite_pkg
// Brief    : Shared constants and types for the AXI4-Lite UART-lite slave.
// Revision : 1.0 - initial release
// ============================================================================
package uart_lite_pkg;

  localparam logic [1:0] UART_REG_RX   = 2'd0;
  localparam logic [1:0] UART_REG_TX   = 2'd1;
  localparam logic [1:0] UART_REG_STAT = 2'd2;
  localparam logic [1:0] UART_REG_CTRL = 2'd3;

  localparam int STAT_RX_VALID  = 0;
  localparam int STAT_RX_FULL   = 1;
  localparam int STAT_TX_EMPTY  = 2;
  localparam int STAT_TX_FULL   = 3;
  localparam int STAT_OVERRUN   = 5;
  localparam int STAT_FRAME_ERR = 7;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_lite_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_lite_fifo
// Brief    : Synchronous first-word-fall-through FIFO with clear.
// Revision : 1.0 - initial release
// ============================================================================
module uart_lite_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             clr,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is honoured only when a pop frees a slot.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/uart_lite_slave.sv
`default_nettype none
// ============================================================================
// Module   : uart_lite_slave
// Brief    : AXI4-Lite UART-lite responder, 8N1, TX/RX FIFOs.
//            Define UART_LITE_SLAVE_LOOPBACK_EN to feed the receiver from tx.
// Revision : 1.0 - initial release
// ============================================================================
module uart_lite_slave
  import uart_lite_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic        rx,
  output logic        tx
);

  localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0);

  logic        awready_q, arready_q, bvalid_q, rvalid_q;
  logic [31:0] rdata_q, rd_mux;
  logic        wr_acc, rd_acc, stat_rd;
  logic [1:0]  wr_reg, rd_reg;
  logic [7:0]  stat;
  logic        overrun_q, frame_err_q, ovr_set, fe_set;

  logic       tx_push, tx_pop, tx_clr, tx_full, tx_empty;
  logic [7:0] tx_dout;
  logic       rx_push, rx_pop, rx_clr, rx_full, rx_empty;
  logic [7:0] rx_dout;

  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d, tx_bit_end;

  uart_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_s1_q, rx_s2_q, rx_prev_q, rx_line, rx_bit_end;

  logic unused_axi_bits;
  assign unused_axi_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata[31:8], s_axi_wstrb};

`ifdef UART_LITE_SLAVE_LOOPBACK_EN
  logic unused_rx_pin;
  assign unused_rx_pin = rx;
  assign rx_line       = tx_q;
`else
  assign rx_line = rx;
`endif

  // ---------------------------------------------------------------- AXI side
  assign wr_reg  = s_axi_awaddr[3:2];
  assign rd_reg  = s_axi_araddr[3:2];
  assign wr_acc  = awready_q && s_axi_awvalid && s_axi_wvalid;
  assign rd_acc  = arready_q && s_axi_arvalid;
  assign stat_rd = rd_acc && (rd_reg == UART_REG_STAT);

  assign tx_push = wr_acc && (wr_reg == UART_REG_TX);
  assign tx_clr  = wr_acc && (wr_reg == UART_REG_CTRL) && s_axi_wdata[0];
  assign rx_clr  = wr_acc && (wr_reg == UART_REG_CTRL) && s_axi_wdata[1];
  assign rx_pop  = rd_acc && (rd_reg == UART_REG_RX);

  always_comb begin
    stat                 = '0;
    stat[STAT_RX_VALID]  = !rx_empty;
    stat[STAT_RX_FULL]   = rx_full;
    stat[STAT_TX_EMPTY]  = tx_empty;
    stat[STAT_TX_FULL]   = tx_full;
    stat[STAT_OVERRUN]   = overrun_q;
    stat[STAT_FRAME_ERR] = frame_err_q;
    case (rd_reg)
      UART_REG_RX:   rd_mux = rx_empty ? 32'h0 : {24'h0, rx_dout};
      UART_REG_STAT: rd_mux = {24'h0, stat};
      default:       rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= s_axi_awvalid && s_axi_wvalid && !bvalid_q && !awready_q;
      arready_q <= s_axi_arvalid && !rvalid_q && !arready_q;
      if (wr_acc)            bvalid_q <= 1'b1;
      else if (s_axi_bready) bvalid_q <= 1'b0;
      if (rd_acc) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = AXI_RESP_OKAY;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = AXI_RESP_OKAY;

  // A concurrent pop frees the slot, so only an unpopped full FIFO overruns.
  assign ovr_set = rx_push && rx_full && !rx_pop && !rx_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= ovr_set | (overrun_q & ~stat_rd);
      frame_err_q <= fe_set | (frame_err_q & ~stat_rd);
    end
  end

  uart_lite_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .din(s_axi_wdata[7:0]), .pop(tx_pop),
    .clr(tx_clr), .full(tx_full), .empty(tx_empty), .dout(tx_dout)
  );

  uart_lite_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .din(rx_shift_q), .pop(rx_pop),
    .clr(rx_clr), .full(rx_full), .empty(rx_empty), .dout(rx_dout)
  );

  // ---------------------------------------------------------------- TX FSM
  assign tx_bit_end = (tx_cnt_q == BIT_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      UART_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty && !tx_clr) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_dout;
          tx_state_d = UART_START;
        end
      end
      UART_START: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_idx_d   = '0;
        tx_state_d = UART_DATA;
      end
      UART_DATA: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_idx_d   = tx_idx_q + 3'd1;
        if (tx_idx_q == 3'd7) tx_state_d = UART_STOP;
      end
      UART_STOP: if (tx_bit_end) begin
        tx_cnt_d = '0;
        // Chain straight into the next start bit so frames are back-to-back.
        if (!tx_empty && !tx_clr) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_dout;
          tx_state_d = UART_START;
        end else begin
          tx_state_d = UART_IDLE;
        end
      end
      default: tx_state_d = UART_IDLE;
    endcase
    case (tx_state_d)
      UART_START: tx_d = 1'b0;
      UART_DATA:  tx_d = tx_shift_d[0];
      default:    tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

  // ---------------------------------------------------------------- RX FSM
  assign rx_bit_end = (rx_cnt_q == BIT_LAST);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    fe_set     = 1'b0;
    case (rx_state_q)
      UART_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = UART_START;
      end
      UART_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_idx_d   = '0;
        rx_state_d = rx_s2_q ? UART_IDLE : UART_DATA;
      end
      UART_DATA: if (rx_bit_end) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_idx_d   = rx_idx_q + 3'd1;
        if (rx_idx_q == 3'd7) rx_state_d = UART_STOP;
      end
      UART_STOP: if (rx_bit_end) begin
        rx_cnt_d   = '0;
        rx_push    = rx_s2_q;
        fe_set     = !rx_s2_q;
        rx_state_d = UART_IDLE;
      end
      default: rx_state_d = UART_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= UART_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_state_q <= UART_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q    <= rx_line;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_lite_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_lite_slave
// Brief    : Directed scoreboard bench for uart_lite_slave (CLKS_PER_BIT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_lite_slave;

  localparam int CPB   = 8;
  localparam int DEPTH = 16;
  localparam logic [1:0] R_RX = 2'd0, R_TX = 2'd1, R_STAT = 2'd2, R_CTRL = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [3:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic        rx = 1'b1;
  logic        tx;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int wr_acc_cyc = 0;
  int tx_fall_cyc = -1;
  int tx_fall_prev = -1;
  bit mon_en = 1'b0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_lite_slave #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .rx(rx), .tx(tx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic axi_write(input logic [1:0] sel, input logic [7:0] d);
    int n = 0;
    s_axi_awaddr  = {sel, 2'b00};
    s_axi_wdata   = {24'h0, d};
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    while (!(s_axi_awready && s_axi_wready) && n < 20) begin
      tick(1);
      n++;
    end
    chk("wr_accept", {s_axi_awready, s_axi_wready}, 2'b11);
    wr_acc_cyc = cyc;
    tick(1);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    chk("wr_bvalid_lat", {s_axi_bvalid, s_axi_awready, s_axi_bresp}, 4'b1000);
    s_axi_bready = 1'b1;
    tick(1);
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [1:0] sel, output logic [31:0] d);
    int n = 0;
    s_axi_araddr  = {sel, 2'b00};
    s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 20) begin
      tick(1);
      n++;
    end
    tick(1);
    s_axi_arvalid = 1'b0;
    chk("rd_rvalid_lat", {s_axi_rvalid, s_axi_rresp}, 3'b100);
    d = s_axi_rdata;
    s_axi_rready = 1'b1;
    tick(1);
    s_axi_rready = 1'b0;
  endtask

  task automatic stat_chk(input string tag, input logic [7:0] exp);
    logic [31:0] d;
    axi_read(R_STAT, d);
    chk(tag, d, {24'h0, exp});
  endtask

  task automatic rx_chk(input string tag);
    logic [31:0] d;
    logic [7:0]  e;
    axi_read(R_RX, d);
    e = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'h00;
    chk(tag, d, {24'h0, e});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
  endtask

  // Decodes every frame on tx at mid-bit and compares it with the scoreboard.
  initial begin : tx_monitor
    logic [7:0] b;
    logic       st, sp;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && rst_n && tx === 1'b0) begin
        tx_fall_prev = tx_fall_cyc;
        tx_fall_cyc  = cyc;
        tick(CPB / 2);
        st = tx;
        for (int i = 0; i < 8; i++) begin
          tick(CPB);
          b[i] = tx;
        end
        tick(CPB);
        sp = tx;
        if (mon_en) begin
          chk("tx_start_stop", {st, sp}, 2'b01);
          chk("tx_expected_avail", tx_exp_q.size() > 0, 1);
          if (tx_exp_q.size() > 0) chk("tx_byte", b, tx_exp_q.pop_front());
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] d;
    int seen;

    tick(3);
    chk("reset_handshake", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, tx}, 6'b000001);
    chk("reset_rdata", s_axi_rdata, 32'h0);
    chk("reset_resp", {s_axi_bresp, s_axi_rresp}, 4'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick(2);
    stat_chk("stat_after_reset", 8'h04);

`ifdef UART_LITE_SLAVE_LOOPBACK_EN
    tx_exp_q.push_back(8'h55);
    rx_exp_q.push_back(8'h55);
    axi_write(R_TX, 8'h55);
    tx_exp_q.push_back(8'hAA);
    rx_exp_q.push_back(8'hAA);
    axi_write(R_TX, 8'hAA);
    tick(20 * CPB + 10);
    rx_chk("loopback_rx0");
    rx_chk("loopback_rx1");
`else
    // Single TX byte: latency, bit pattern, back to idle.
    tx_exp_q.push_back(8'hA5);
    axi_write(R_TX, 8'hA5);
    tick(10 * CPB + 10);
    chk("tx_fall_latency", tx_fall_cyc - wr_acc_cyc, 2);
    stat_chk("stat_after_tx", 8'h04);

    // Reset while a frame is on the wire.
    mon_en = 1'b0;
    axi_write(R_TX, 8'h3C);
    tick(3 * CPB);
    rst_n = 1'b0;
    tick(1);
    chk("tx_high_in_reset", tx, 1'b1);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    mon_en = 1'b1;
    chk("tx_high_after_reset", tx, 1'b1);
    stat_chk("stat_after_midframe_reset", 8'h04);

    // Single RX byte.
    rx_exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    tick(3);
    stat_chk("stat_rx_valid", 8'h05);
    rx_chk("rx_byte");
    stat_chk("stat_rx_drained", 8'h04);
    axi_read(R_RX, d);
    chk("rx_empty_read", d, 32'h0);

    // Overrun: one byte more than the FIFO holds.
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i < DEPTH) rx_exp_q.push_back(8'(8'h11 + 7 * i));
      send_byte(8'(8'h11 + 7 * i), 1'b1);
    end
    tick(3);
    stat_chk("stat_overrun", 8'h27);
    stat_chk("stat_overrun_cleared", 8'h07);
    for (int i = 0; i < DEPTH; i++) rx_chk("rx_fifo_order");
    stat_chk("stat_rx_all_drained", 8'h04);

    // Framing error.
    send_byte(8'h5A, 1'b0);
    tick(3);
    stat_chk("stat_frame_err", 8'h84);
    stat_chk("stat_frame_err_cleared", 8'h04);

    // Short glitch must not start a frame.
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(12 * CPB);
    stat_chk("stat_after_glitch", 8'h04);

    // CTRL clear of the RX FIFO.
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    tick(3);
    stat_chk("stat_two_rx", 8'h05);
    axi_write(R_CTRL, 8'h02);
    stat_chk("stat_rx_cleared", 8'h04);
`endif

    // AW without W must not be accepted.
    s_axi_awaddr  = {R_TX, 2'b00};
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b0;
    seen = 0;
    repeat (5) begin
      tick(1);
      seen += int'(s_axi_awready);
    end
    chk("aw_without_w", seen, 0);
    tx_exp_q.push_back(8'h81);
    axi_write(R_TX, 8'h81);
    tick(10 * CPB + 10);

`ifndef UART_LITE_SLAVE_LOOPBACK_EN
    // Fill the TX FIFO behind an active frame; the extra write is dropped.
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i <= DEPTH) tx_exp_q.push_back(8'(8'h20 + i));
      axi_write(R_TX, 8'(8'h20 + i));
    end
    stat_chk("stat_tx_full", 8'h08);
    tick((DEPTH + 1) * 10 * CPB + 20);
    chk("tx_back_to_back", tx_fall_cyc - tx_fall_prev, 10 * CPB);
    chk("tx_scoreboard_empty", tx_exp_q.size(), 0);
    stat_chk("stat_final", 8'h04);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
